// File: rtl/logic_capture_ts.sv
// Transition-capture engine: synchronises the channel bus, arms on a mask/value
// trigger, then writes one {delta, sample} BRAM entry per input change or keepalive.
module logic_capture_ts #(
  parameter int CH  = 8,
  parameter int AW  = 18,
  parameter int TSW = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [CH-1:0]     datain,
  input  logic              start,
  input  logic              stop,
  input  logic              circular,
  input  logic [CH-1:0]     trig_mask,
  input  logic [CH-1:0]     trig_value,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [TSW+CH-1:0] mem_wdata,
  output logic              armed,
  output logic              capturing,
  output logic              done,
  output logic              wrapped,
  output logic [AW-1:0]     wr_ptr,
  output logic [CH-1:0]     rising,
  output logic [CH-1:0]     falling
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [AW-1:0]  LAST_ADDR = '1;
  localparam logic [TSW-1:0] CNT_MAX   = '1;

  logic [CH-1:0]     sync1_q, cur_q, prev_q;
  logic [1:0]        state_q, state_d;
  logic              circ_q, circ_d;
  logic [CH-1:0]     mask_q, mask_d;
  logic [CH-1:0]     value_q, value_d;
  logic [TSW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              wrapped_q, wrapped_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [TSW+CH-1:0] mem_wdata_q, mem_wdata_d;
  logic [CH-1:0]     rising_q, rising_d;
  logic [CH-1:0]     falling_q, falling_d;
  logic              armed_q, capturing_q, done_q;

  logic              wr_en;
  logic [TSW-1:0]    delta;
  logic              changed, match;

  assign changed = (cur_q != prev_q);
  assign match   = (((cur_q ^ value_q) & mask_q) == '0);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    circ_d      = circ_q;
    mask_d      = mask_q;
    value_d     = value_q;
    cnt_d       = cnt_q + TSW'(1);
    wr_ptr_d    = wr_ptr_q;
    wrapped_d   = wrapped_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rising_d    = '0;
    falling_d   = '0;
    wr_en       = 1'b0;
    delta       = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // stop overrides a simultaneous start
        if (start && !stop) begin
          state_d   = S_ARMED;
          circ_d    = circular;
          mask_d    = trig_mask;
          value_d   = trig_value;
          wr_ptr_d  = '0;
          wrapped_d = 1'b0;
          cnt_d     = '0;
        end
      end
      S_ARMED: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (match) begin
          wr_en   = 1'b1;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (changed) begin
          wr_en     = 1'b1;
          delta     = cnt_q;
          rising_d  = cur_q & ~prev_q;
          falling_d = ~cur_q & prev_q;
        end else if (cnt_q == CNT_MAX) begin
          // keepalive: same sample as the previous entry, saturated delta
          wr_en = 1'b1;
          delta = CNT_MAX;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_en) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = wr_ptr_q;
      mem_wdata_d = {delta, cur_q};
      wr_ptr_d    = wr_ptr_q + AW'(1);
      cnt_d       = TSW'(1);
      if (wr_ptr_q == LAST_ADDR) begin
        if (circ_q) wrapped_d = 1'b1;
        else        state_d   = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= '0;
      cur_q       <= '0;
      prev_q      <= '0;
      state_q     <= S_IDLE;
      circ_q      <= 1'b0;
      mask_q      <= '0;
      value_q     <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      wrapped_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rising_q    <= '0;
      falling_q   <= '0;
      armed_q     <= 1'b0;
      capturing_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // this is what makes sync1 -> cur -> prev a real shift chain.
      sync1_q     <= datain;
      cur_q       <= sync1_q;
      prev_q      <= cur_q;
      state_q     <= state_d;
      circ_q      <= circ_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      wrapped_q   <= wrapped_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rising_q    <= rising_d;
      falling_q   <= falling_d;
      armed_q     <= (state_d == S_ARMED);
      capturing_q <= (state_d == S_CAPTURE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign mem_en    = mem_we_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign armed     = armed_q;
  assign capturing = capturing_q;
  assign done      = done_q;
  assign wrapped   = wrapped_q;
  assign wr_ptr    = wr_ptr_q;
  assign rising    = rising_q;
  assign falling   = falling_q;

endmodule

// File: tb/tb_logic_capture_ts.sv
// Directed bench for logic_capture_ts: a default-size instance and a small one
// (AW=3, TSW=4) share stimulus; each logs its BRAM writes for per-scenario checks.
module tb_logic_capture_ts;

  typedef struct {
    int          cyc;
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  rise;
    logic [7:0]  fall;
  } wr_t;

  logic       clk;
  logic       resetn;
  logic [7:0] datain;
  logic       start, stop, circular;
  logic [7:0] trig_mask, trig_value;

  logic        d_mem_en, d_mem_we, d_armed, d_capturing, d_done, d_wrapped;
  logic [17:0] d_mem_addr, d_wr_ptr;
  logic [23:0] d_mem_wdata;
  logic [7:0]  d_rising, d_falling;

  logic        s_mem_en, s_mem_we, s_armed, s_capturing, s_done, s_wrapped;
  logic [2:0]  s_mem_addr, s_wr_ptr;
  logic [11:0] s_mem_wdata;
  logic [7:0]  s_rising, s_falling;

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc   = 0;
  wr_t q_d[$];
  wr_t q_s[$];
  wr_t rd, rs;

  logic_capture_ts #(.CH(8), .AW(18), .TSW(16)) u_dut (
    .clk(clk), .resetn(resetn), .datain(datain), .start(start), .stop(stop),
    .circular(circular), .trig_mask(trig_mask), .trig_value(trig_value),
    .mem_en(d_mem_en), .mem_we(d_mem_we), .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata),
    .armed(d_armed), .capturing(d_capturing), .done(d_done), .wrapped(d_wrapped),
    .wr_ptr(d_wr_ptr), .rising(d_rising), .falling(d_falling)
  );

  logic_capture_ts #(.CH(8), .AW(3), .TSW(4)) u_small (
    .clk(clk), .resetn(resetn), .datain(datain), .start(start), .stop(stop),
    .circular(circular), .trig_mask(trig_mask), .trig_value(trig_value),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .armed(s_armed), .capturing(s_capturing), .done(s_done), .wrapped(s_wrapped),
    .wr_ptr(s_wr_ptr), .rising(s_rising), .falling(s_falling)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write logger, sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (d_mem_we) begin
      rd.cyc = cyc; rd.en = d_mem_en; rd.addr = 32'(d_mem_addr); rd.data = 32'(d_mem_wdata);
      rd.rise = d_rising; rd.fall = d_falling;
      q_d.push_back(rd);
    end
    if (s_mem_we) begin
      rs.cyc = cyc; rs.en = s_mem_en; rs.addr = 32'(s_mem_addr); rs.data = 32'(s_mem_wdata);
      rs.rise = s_rising; rs.fall = s_falling;
      q_s.push_back(rs);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    q_d.delete();
    q_s.delete();
  endtask

  task automatic stop_all();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic arm(input logic [7:0] mask, input logic [7:0] value, input logic circ);
    @(negedge clk);
    trig_mask = mask; trig_value = value; circular = circ; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; datain = 8'h00; start = 1'b0; stop = 1'b0;
    circular = 1'b0; trig_mask = 8'h00; trig_value = 8'h00;
    repeat (2) @(negedge clk);
    n_cmp++; if ({d_mem_en, d_mem_we, d_armed, d_capturing, d_done, d_wrapped} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags_def: got %b want 000000",
        {d_mem_en, d_mem_we, d_armed, d_capturing, d_done, d_wrapped}); end
    n_cmp++; if ({d_mem_addr, d_wr_ptr, d_mem_wdata, d_rising, d_falling} !== 76'b0) begin
      n_err++; $display("FAIL reset_data_def: addr %h ptr %h wdata %h rise %h fall %h want 0",
        d_mem_addr, d_wr_ptr, d_mem_wdata, d_rising, d_falling); end
    n_cmp++; if ({s_mem_we, s_armed, s_capturing, s_done, s_wrapped, s_wr_ptr, s_mem_wdata} !== 20'b0) begin
      n_err++; $display("FAIL reset_small: got %h want 0",
        {s_mem_we, s_armed, s_capturing, s_done, s_wrapped, s_wr_ptr, s_mem_wdata}); end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_stop_idle();
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({d_armed, d_capturing, d_done} !== 3'b000) begin
      n_err++; $display("FAIL start_stop_idle: armed/capt/done got %b want 000",
        {d_armed, d_capturing, d_done}); end
  endtask

  task automatic test_immediate();
    clear_logs();
    @(negedge clk);
    trig_mask = 8'h00; trig_value = 8'h00; circular = 1'b0; start = 1'b1; datain = 8'h01;
    @(negedge clk);
    start = 1'b0; datain = 8'h03;
    n_cmp++; if (d_armed !== 1'b1) begin
      n_err++; $display("FAIL imm_armed: got %b want 1", d_armed); end
    repeat (4) @(negedge clk);
    n_cmp++; if (q_d.size() !== 3) begin
      n_err++; $display("FAIL imm_count: got %0d writes want 3", q_d.size()); end
    if (q_d.size() >= 3) begin
      n_cmp++; if (q_d[0].addr !== 32'd0 || q_d[0].data !== 32'h000000 || q_d[0].en !== 1'b1) begin
        n_err++; $display("FAIL imm_e0: addr %0d data %h en %b want 0/000000/1",
          q_d[0].addr, q_d[0].data, q_d[0].en); end
      n_cmp++; if (q_d[1].addr !== 32'd1 || q_d[1].data !== 32'h000101 || q_d[1].rise !== 8'h01) begin
        n_err++; $display("FAIL imm_e1: addr %0d data %h rise %h want 1/000101/01",
          q_d[1].addr, q_d[1].data, q_d[1].rise); end
      n_cmp++; if (q_d[2].addr !== 32'd2 || q_d[2].data !== 32'h000103 || q_d[2].rise !== 8'h02) begin
        n_err++; $display("FAIL imm_e2: addr %0d data %h rise %h want 2/000103/02",
          q_d[2].addr, q_d[2].data, q_d[2].rise); end
      n_cmp++; if (q_d[1].cyc - q_d[0].cyc !== 1 || q_d[2].cyc - q_d[1].cyc !== 1) begin
        n_err++; $display("FAIL imm_b2b: write gaps %0d,%0d cycles want 1,1",
          q_d[1].cyc - q_d[0].cyc, q_d[2].cyc - q_d[1].cyc); end
    end
    n_cmp++; if (d_wr_ptr !== 18'd3 || d_capturing !== 1'b1) begin
      n_err++; $display("FAIL imm_final: wr_ptr %0d capturing %b want 3/1", d_wr_ptr, d_capturing); end
    // a start during capture must be ignored
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (d_wr_ptr !== 18'd3 || d_capturing !== 1'b1 || d_armed !== 1'b0) begin
      n_err++; $display("FAIL start_ignored: wr_ptr %0d capt %b armed %b want 3/1/0",
        d_wr_ptr, d_capturing, d_armed); end
  endtask

  task automatic test_pattern();
    stop_all();
    datain = 8'h00;
    repeat (3) @(negedge clk);
    clear_logs();
    arm(8'h80, 8'h80, 1'b0);
    for (int i = 0; i < 10; i++) begin
      datain = (i % 2 == 0) ? 8'h01 : 8'h00;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (q_d.size() !== 0 || d_armed !== 1'b1) begin
      n_err++; $display("FAIL pat_armed_quiet: writes %0d armed %b want 0/1", q_d.size(), d_armed); end
    datain = 8'h81;
    repeat (4) @(negedge clk);
    n_cmp++; if (q_d.size() !== 1) begin
      n_err++; $display("FAIL pat_count: got %0d writes want 1", q_d.size()); end
    else begin
      n_cmp++; if (q_d[0].addr !== 32'd0 || q_d[0].data !== 32'h000081) begin
        n_err++; $display("FAIL pat_trig: addr %0d data %h want 0/000081", q_d[0].addr, q_d[0].data); end
    end
    n_cmp++; if (d_capturing !== 1'b1) begin
      n_err++; $display("FAIL pat_capturing: got %b want 1", d_capturing); end
    datain = 8'h01;
    repeat (4) @(negedge clk);
    n_cmp++; if (q_d.size() !== 2) begin
      n_err++; $display("FAIL fall_count: got %0d writes want 2", q_d.size()); end
    else begin
      n_cmp++; if (q_d[1].data !== 32'h000401 || q_d[1].fall !== 8'h80 || q_d[1].rise !== 8'h00) begin
        n_err++; $display("FAIL fall_entry: data %h fall %h rise %h want 000401/80/00",
          q_d[1].data, q_d[1].fall, q_d[1].rise); end
    end
  endtask

  task automatic test_keepalive();
    stop_all();
    datain = 8'h5A;
    repeat (3) @(negedge clk);
    clear_logs();
    arm(8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 60 && q_s.size() < 3; i++) @(negedge clk);
    n_cmp++; if (q_s.size() !== 3) begin
      n_err++; $display("FAIL ka_count: got %0d writes want 3 within bound", q_s.size()); end
    else begin
      n_cmp++; if (q_s[0].data !== 32'h05A) begin
        n_err++; $display("FAIL ka_trig: data %h want 05A", q_s[0].data); end
      n_cmp++; if (q_s[1].data !== 32'hF5A || q_s[2].data !== 32'hF5A
                   || (q_s[1].rise | q_s[1].fall | q_s[2].rise | q_s[2].fall) !== 8'h00) begin
        n_err++; $display("FAIL ka_entry: data %h,%h edges %h want F5A,F5A,00", q_s[1].data,
          q_s[2].data, q_s[1].rise | q_s[1].fall | q_s[2].rise | q_s[2].fall); end
      n_cmp++; if (q_s[1].cyc - q_s[0].cyc !== 15 || q_s[2].cyc - q_s[1].cyc !== 15) begin
        n_err++; $display("FAIL ka_period: gaps %0d,%0d want 15,15",
          q_s[1].cyc - q_s[0].cyc, q_s[2].cyc - q_s[1].cyc); end
      repeat (2) @(negedge clk);
      datain = 8'h5B;
      repeat (6) @(negedge clk);
      n_cmp++; if (q_s.size() < 4) begin
        n_err++; $display("FAIL ka_change_count: got %0d writes want 4", q_s.size()); end
      else begin
        n_cmp++; if (q_s[3].data !== 32'h55B || q_s[3].rise !== 8'h01 || q_s[3].cyc - q_s[2].cyc !== 5) begin
          n_err++; $display("FAIL ka_change: data %h rise %h gap %0d want 55B/01/5",
            q_s[3].data, q_s[3].rise, q_s[3].cyc - q_s[2].cyc); end
      end
    end
  endtask

  task automatic test_full();
    stop_all();
    datain = 8'h00;
    repeat (3) @(negedge clk);
    clear_logs();
    arm(8'h00, 8'h00, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      datain = 8'(i);
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    n_cmp++; if (q_s.size() !== 8) begin
      n_err++; $display("FAIL full_count: got %0d writes want 8", q_s.size()); end
    else begin
      n_cmp++; if (q_s[7].addr !== 32'd7 || q_s[7].data !== 32'h107) begin
        n_err++; $display("FAIL full_last: addr %0d data %h want 7/107", q_s[7].addr, q_s[7].data); end
    end
    n_cmp++; if (s_done !== 1'b1 || s_wr_ptr !== 3'd0 || s_capturing !== 1'b0 || s_wrapped !== 1'b0) begin
      n_err++; $display("FAIL full_oneshot: done %b ptr %0d capt %b wrapped %b want 1/0/0/0",
        s_done, s_wr_ptr, s_capturing, s_wrapped); end

    stop_all();
    clear_logs();
    arm(8'h00, 8'h00, 1'b1);
    for (int i = 10; i <= 18; i++) begin
      datain = 8'(i);
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    n_cmp++; if (q_s.size() !== 10) begin
      n_err++; $display("FAIL circ_count: got %0d writes want 10", q_s.size()); end
    else begin
      n_cmp++; if (q_s[8].addr !== 32'd0 || q_s[9].addr !== 32'd1 || q_s[8].data !== 32'h111) begin
        n_err++; $display("FAIL circ_wrap: addrs %0d,%0d data %h want 0,1/111",
          q_s[8].addr, q_s[9].addr, q_s[8].data); end
    end
    n_cmp++; if (s_wrapped !== 1'b1 || s_capturing !== 1'b1 || s_wr_ptr !== 3'd2 || d_wrapped !== 1'b0) begin
      n_err++; $display("FAIL circ_state: wrapped %b capt %b ptr %0d big_wrapped %b want 1/1/2/0",
        s_wrapped, s_capturing, s_wr_ptr, d_wrapped); end
  endtask

  task automatic test_stop_collision();
    clear_logs();
    @(negedge clk); datain = 8'h00;
    @(negedge clk);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (q_d.size() !== 0 || q_s.size() !== 0) begin
      n_err++; $display("FAIL stop_no_write: writes %0d/%0d want 0/0", q_d.size(), q_s.size()); end
    n_cmp++; if (d_done !== 1'b1 || d_capturing !== 1'b0 || s_done !== 1'b1) begin
      n_err++; $display("FAIL stop_done: done %b capt %b small_done %b want 1/0/1",
        d_done, d_capturing, s_done); end
  endtask

  task automatic test_reset_mid();
    arm(8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      datain = 8'(8'h20 + i);
      @(negedge clk);
    end
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    n_cmp++; if ({d_mem_en, d_mem_we, d_armed, d_capturing, d_done, d_wrapped} !== 6'b0
                 || {d_mem_addr, d_wr_ptr, d_mem_wdata, d_rising, d_falling} !== 76'b0) begin
      n_err++; $display("FAIL reset_mid: flags %b ptr %h wdata %h want all 0",
        {d_mem_en, d_mem_we, d_armed, d_capturing, d_done, d_wrapped}, d_wr_ptr, d_mem_wdata); end
    @(negedge clk);
    resetn = 1'b1;
    datain = 8'h3C;
    clear_logs();
    repeat (4) @(negedge clk);
    n_cmp++; if ({d_armed, d_capturing, d_done} !== 3'b000 || q_d.size() !== 0) begin
      n_err++; $display("FAIL reset_idle: armed/capt/done %b writes %0d want 000/0",
        {d_armed, d_capturing, d_done}, q_d.size()); end
  endtask

  initial begin
    test_reset();
    test_start_stop_idle();
    test_immediate();
    test_pattern();
    test_keepalive();
    test_full();
    test_stop_collision();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
